// File: rtl/product_acc_pkg.sv
// Shared widths, state encoding and saturation constant for the product accumulator family.
package product_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_CNT_W  = 8;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle; slave side is the accumulator, master side its environment.
interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [CNT_W-1:0]  len_i;
    logic              prod_valid_i;
    logic              prod_ready_o;
    logic [PROD_W-1:0] product_i;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic [ACC_W-1:0]  sum_o;
    logic              overflow_o;

    modport slave (
        input  len_i, prod_valid_i, product_i, sum_ready_i,
        output prod_ready_o, sum_valid_o, sum_o, overflow_o
    );

    modport master (
        output len_i, prod_valid_i, product_i, sum_ready_i,
        input  prod_ready_o, sum_valid_o, sum_o, overflow_o
    );
endinterface

// File: rtl/array_multiplier8.sv
// Combinational 8x8 unsigned shift-and-add array multiplier; feeds the accumulator.
// Latency 0, no handshake.
module array_multiplier8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] result_o
);
    always_comb begin
        result_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) begin
                result_o = result_o + ({8'b0, a_i} << i);
            end
        end
    end
endmodule

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: A_W accumulator plus zero-extended B_W operand, clamps to all-ones.
// Combinational; sat flags that the true sum did not fit in A_W bits (requires A_W >= B_W).
module sat_adder #(
    parameter int A_W = 20,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           sat
);
    logic [A_W:0] wide;

    // One extra bit captures the carry so saturation is exact.
    assign wide = {1'b0, a} + (A_W + 1)'(b);
    assign sat  = wide[A_W];
    assign sum  = sat ? '1 : wide[A_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// Saturating MAC reduction: sums len products then presents one sum with a sticky overflow flag.
// Sum is valid on the edge after the last beat; product input stalls while a sum waits for sum_ready_i.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    product_accumulator_if.slave  bus
);
    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              sum_vld_q, sum_vld_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sum_ovf_q, sum_ovf_d;

    logic              beat;
    logic              last_beat;
    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_sum;
    logic              add_sat;
    logic [CNT_W-1:0]  first_cnt;

    assign bus.prod_ready_o = (state_q != HOLD);
    assign beat             = bus.prod_valid_i && (state_q != HOLD);

    // First beat of a sum adds to zero, so the adder doubles as the load path.
    assign add_a     = (state_q == ACCUM) ? acc_q : '0;
    assign first_cnt = (bus.len_i == '0) ? '0 : bus.len_i - CNT_W'(1);

    sat_adder #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_adder (
        .a   (add_a),
        .b   (bus.product_i),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_vld_d = sum_vld_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        last_beat = 1'b0;

        if (clear_i) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            sum_vld_d = 1'b0;
            sum_d     = '0;
            sum_ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d     = add_sum;
                        ovf_d     = add_sat;
                        cnt_d     = first_cnt;
                        state_d   = ACCUM;
                        last_beat = (first_cnt == '0);
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d     = add_sum;
                        ovf_d     = ovf_q | add_sat;
                        cnt_d     = cnt_q - CNT_W'(1);
                        last_beat = (cnt_q == CNT_W'(1));
                    end
                end
                HOLD: begin
                    if (bus.sum_ready_i) begin
                        state_d   = IDLE;
                        sum_vld_d = 1'b0;
                        sum_d     = '0;
                        sum_ovf_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Output registers capture the final value so sum_o is zero outside HOLD.
            if (last_beat) begin
                state_d   = HOLD;
                sum_vld_d = 1'b1;
                sum_d     = acc_d;
                sum_ovf_d = ovf_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_vld_q <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_vld_q <= sum_vld_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

    assign bus.sum_valid_o = sum_vld_q;
    assign bus.sum_o       = sum_q;
    assign bus.overflow_o  = sum_ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// End-to-end bench: array_multiplier8 feeds product_accumulator, checked against an arithmetic reference.
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] op_a_drv;
    logic [7:0] op_b_drv;

    int n_checks;
    int n_errors;

    int op_a [64];
    int op_b [64];

    product_accumulator_if bus ();

    array_multiplier8 u_mult (
        .a_i      (op_a_drv),
        .b_i      (op_b_drv),
        .result_o (bus.product_i)
    );

    product_accumulator dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact sum of products, clamped to the accumulator range.
    task automatic model(input int n, output logic [19:0] s, output logic o);
        longint total;
        total = 0;
        for (int i = 0; i < n; i++) total += longint'(op_a[i]) * longint'(op_b[i]);
        if (total > longint'(ACC_MAX)) begin
            s = ACC_MAX;
            o = 1'b1;
        end else begin
            s = 20'(total);
            o = 1'b0;
        end
    endtask

    task automatic run_sum(input int len, input int fixed_gap, input int gap_pct,
                           input int ready_dly, input string tag);
        int         eff;
        logic [19:0] exp_s;
        logic        exp_o;
        eff = (len == 0) ? 1 : len;
        model(eff, exp_s, exp_o);
        for (int i = 0; i < eff; i++) begin
            for (int g = 0; g < ((i > 0) ? fixed_gap : 0); g++) begin
                bus.prod_valid_i = 1'b0;
                op_a_drv = 8'($urandom);
                @(negedge clk);
            end
            for (int g = 0; g < 3 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct; g++) begin
                bus.prod_valid_i = 1'b0;
                op_b_drv = 8'($urandom);
                @(negedge clk);
            end
            check({tag, "_prod_ready"}, 32'(bus.prod_ready_o), 32'd1);
            check({tag, "_no_early_sum"}, 32'(bus.sum_valid_o), 32'd0);
            bus.prod_valid_i = 1'b1;
            op_a_drv = 8'(op_a[i]);
            op_b_drv = 8'(op_b[i]);
            bus.len_i = (i == 0) ? 8'(len) : 8'($urandom);
            @(negedge clk);
        end
        bus.prod_valid_i = 1'b0;
        check({tag, "_sum_valid"}, 32'(bus.sum_valid_o), 32'd1);
        check({tag, "_sum"}, 32'(bus.sum_o), 32'(exp_s));
        check({tag, "_overflow"}, 32'(bus.overflow_o), 32'(exp_o));
        for (int d = 0; d < ready_dly; d++) begin
            bus.prod_valid_i = 1'($urandom);
            op_a_drv = 8'($urandom);
            op_b_drv = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold_ready"}, 32'(bus.prod_ready_o), 32'd0);
            check({tag, "_hold_valid"}, 32'(bus.sum_valid_o), 32'd1);
            check({tag, "_hold_sum"}, 32'(bus.sum_o), 32'(exp_s));
            check({tag, "_hold_ovf"}, 32'(bus.overflow_o), 32'(exp_o));
        end
        bus.prod_valid_i = 1'b0;
        bus.sum_ready_i  = 1'b1;
        @(negedge clk);
        bus.sum_ready_i  = 1'b0;
        check({tag, "_drain_valid"}, 32'(bus.sum_valid_o), 32'd0);
        check({tag, "_drain_sum"}, 32'(bus.sum_o), 32'd0);
        check({tag, "_drain_ready"}, 32'(bus.prod_ready_o), 32'd1);
    endtask

    task automatic set_ops(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) begin
            op_a[i] = a;
            op_b[i] = b;
        end
    endtask

    task automatic abort_seq(input bit use_reset, input string tag);
        bus.len_i = 8'd4;
        for (int i = 0; i < 2; i++) begin
            bus.prod_valid_i = 1'b1;
            op_a_drv = 8'($urandom);
            op_b_drv = 8'($urandom);
            @(negedge clk);
        end
        if (!use_reset) begin
            bus.prod_valid_i = 1'b1;
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            bus.prod_valid_i = 1'b0;
        end else begin
            bus.prod_valid_i = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check({tag, "_rst_valid"}, 32'(bus.sum_valid_o), 32'd0);
            check({tag, "_rst_sum"}, 32'(bus.sum_o), 32'd0);
            check({tag, "_rst_ready"}, 32'(bus.prod_ready_o), 32'd1);
            @(negedge clk);
            rst_n = 1'b1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check({tag, "_no_sum"}, 32'(bus.sum_valid_o), 32'd0);
        end
        set_ops(1, 8'h55, 8'hAA);
        run_sum(1, 0, 0, 0, {tag, "_after"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.len_i = '0;
        bus.prod_valid_i = 1'b0;
        bus.sum_ready_i = 1'b0;
        op_a_drv = '0;
        op_b_drv = '0;

        for (int c = 0; c < 4; c++) begin
            clear = 1'($urandom);
            bus.prod_valid_i = 1'($urandom);
            bus.sum_ready_i = 1'($urandom);
            bus.len_i = 8'($urandom);
            op_a_drv = 8'($urandom);
            op_b_drv = 8'($urandom);
            @(negedge clk);
            check("reset_valid", 32'(bus.sum_valid_o), 32'd0);
            check("reset_sum", 32'(bus.sum_o), 32'd0);
            check("reset_ovf", 32'(bus.overflow_o), 32'd0);
            check("reset_ready", 32'(bus.prod_ready_o), 32'd1);
        end
        clear = 1'b0;
        bus.prod_valid_i = 1'b0;
        bus.sum_ready_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        op_a[0] = 8'h29; op_b[0] = 8'h7A;
        op_a[1] = 8'h11; op_b[1] = 8'h11;
        op_a[2] = 8'h81; op_b[2] = 8'h1C;
        run_sum(3, 0, 0, 0, "basic");

        op_a[0] = 8'h44; op_b[0] = 8'h3B;
        op_a[1] = 8'h34; op_b[1] = 8'h12;
        run_sum(2, 3, 0, 5, "gaps");

        set_ops(16, 8'hFF, 8'hFF);
        run_sum(16, 0, 0, 1, "sat16");
        set_ops(17, 8'hFF, 8'hFF);
        run_sum(17, 0, 0, 1, "sat17");
        set_ops(1, 8'h11, 8'h20);
        run_sum(1, 0, 0, 0, "after_sat");

        set_ops(1, 8'h80, 8'h80);
        run_sum(0, 0, 0, 0, "len0");
        run_sum(1, 0, 0, 0, "len1");

        abort_seq(1'b0, "clear_abort");
        abort_seq(1'b1, "reset_abort");

        for (int t = 0; t < 30; t++) begin
            int len;
            bit heavy;
            len = int'($urandom_range(24));
            heavy = ($urandom_range(3) == 0);
            for (int i = 0; i < 64; i++) begin
                op_a[i] = heavy ? int'($urandom_range(255, 240)) : int'($urandom_range(255));
                op_b[i] = heavy ? int'($urandom_range(255, 240)) : int'($urandom_range(255));
            end
            run_sum(len, 0, 25, int'($urandom_range(3)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
